// File: rtl/tone_gen_axil_slave_if.sv
// ---------------------------------------------------------------------------
// tone_gen_axil_slave_if
// AXI4-Lite bus bundle for the tone generator slave.
//
// Parameters:
//   ADDR_WIDTH  byte-address width of AWADDR/ARADDR
//   DATA_WIDTH  data width of WDATA/RDATA (the slave supports 32 only)
//
// Modports:
//   master  drives AW/W/AR valids, payloads, BREADY and RREADY
//   slave   drives AW/W/AR readies, B response and R data/response
// ---------------------------------------------------------------------------
interface tone_gen_axil_slave_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    // Write address channel
    logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [2:0]                S_AXI_AWPROT;
    logic                      S_AXI_AWVALID;
    logic                      S_AXI_AWREADY;

    // Write data channel
    logic [DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                      S_AXI_WVALID;
    logic                      S_AXI_WREADY;

    // Write response channel
    logic [1:0]                S_AXI_BRESP;
    logic                      S_AXI_BVALID;
    logic                      S_AXI_BREADY;

    // Read address channel
    logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [2:0]                S_AXI_ARPROT;
    logic                      S_AXI_ARVALID;
    logic                      S_AXI_ARREADY;

    // Read data channel
    logic [DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                S_AXI_RRESP;
    logic                      S_AXI_RVALID;
    logic                      S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/tone_gen_axil_slave.sv
// ---------------------------------------------------------------------------
// tone_gen_axil_slave
// AXI4-Lite slave holding four 32-bit registers that drive a square-wave
// tone generator.
//
// Register map (decoded on address bits [3:2]):
//   0x0 CTRL         bit0 enables the tone
//   0x4 HALF_PERIOD  clock cycles per half period of the tone
//   0x8 AMPLITUDE    bits[15:0] give the sample magnitude
//   0xC SCRATCH      general purpose storage
//
// Ports:
//   S_AXI_ACLK    sole clock, rising-edge
//   S_AXI_ARESET  asynchronous active-high reset
//   s_axi         AXI4-Lite bus (slave modport)
//   tone_out      square-wave output, toggles every HALF_PERIOD cycles
//   sample_out    signed 16-bit sample, +AMPLITUDE / -AMPLITUDE / 0
// ---------------------------------------------------------------------------
module tone_gen_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESET,
    tone_gen_axil_slave_if.slave   s_axi,
    output logic                   tone_out,
    output logic [15:0]            sample_out
);

    localparam int STRB_WIDTH = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [1:0] IDX_CTRL        = 2'd0;
    localparam logic [1:0] IDX_HALF_PERIOD = 2'd1;
    localparam logic [1:0] IDX_AMPLITUDE   = 2'd2;

    // Register file
    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

    // Ready gating: held low during reset and released on the first edge after
    logic ready_en;

    // Write channel latches
    logic                          aw_latched;
    logic [1:0]                    aw_index_q;
    logic                          w_latched;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0]         wstrb_q;
    logic                          bvalid_q;

    // Read channel
    logic                          rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

    // Tone state
    logic [31:0] counter;

    // Derived control
    logic                          awready_int;
    logic                          wready_int;
    logic                          arready_int;
    logic                          aw_hs;
    logic                          w_hs;
    logic                          ar_hs;
    logic                          do_write;
    logic [1:0]                    wr_index;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0]         wr_strb;
    logic                          hp_write;
    logic                          tone_enabled;
    logic                          tone_wrap;
    logic                          tone_next;
    logic [15:0]                   amplitude;
    logic [15:0]                   neg_amplitude;
    logic [15:0]                   sample_next;

    // Protection bits and the byte-offset address bits carry no meaning here
    logic unused_inputs;
    assign unused_inputs = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                             s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:0],
                             s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:0]};

    // Readies depend only on registered state, so they can never combinationally
    // loop back through a master that waits for ready before raising valid.
    assign awready_int = ready_en && !aw_latched && !bvalid_q;
    assign wready_int  = ready_en && !w_latched  && !bvalid_q;
    assign arready_int = ready_en && !rvalid_q;

    assign s_axi.S_AXI_AWREADY = awready_int;
    assign s_axi.S_AXI_WREADY  = wready_int;
    assign s_axi.S_AXI_ARREADY = arready_int;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = 2'b00;

    // Merge the latched and the live channel contents, so the register write
    // happens on the very edge where the second of AW/W arrives.
    always_comb begin
        aw_hs    = s_axi.S_AXI_AWVALID && awready_int;
        w_hs     = s_axi.S_AXI_WVALID  && wready_int;
        ar_hs    = s_axi.S_AXI_ARVALID && arready_int;
        wr_index = aw_latched ? aw_index_q : s_axi.S_AXI_AWADDR[3:2];
        wr_data  = w_latched  ? wdata_q    : s_axi.S_AXI_WDATA;
        wr_strb  = w_latched  ? wstrb_q    : s_axi.S_AXI_WSTRB;
        do_write = (aw_latched || aw_hs) && (w_latched || w_hs) && !bvalid_q;
        hp_write = do_write && (wr_index == IDX_HALF_PERIOD);
    end

    // Tone next-state: a HALF_PERIOD write restarts the count and suppresses
    // any toggle that would otherwise land on the same edge.
    always_comb begin
        tone_enabled  = regs[IDX_CTRL][0] && (regs[IDX_HALF_PERIOD] != 32'd0);
        tone_wrap     = tone_enabled && !hp_write &&
                        (counter == regs[IDX_HALF_PERIOD] - 32'd1);
        tone_next     = tone_enabled ? (tone_out ^ tone_wrap) : 1'b0;
        amplitude     = regs[IDX_AMPLITUDE][15:0];
        neg_amplitude = 16'd0 - amplitude;
        sample_next   = 16'd0;
        if (tone_enabled) begin
            sample_next = tone_next ? amplitude : neg_amplitude;
        end
    end

    // Releases the bus readies one edge after reset goes away.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Write handshake tracking: AW and W are captured independently and stay
    // latched (blocking further transfers) until the B handshake completes.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            aw_latched <= 1'b0;
            aw_index_q <= 2'd0;
            w_latched  <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
        end else begin
            if (bvalid_q && s_axi.S_AXI_BREADY) begin
                bvalid_q   <= 1'b0;
                aw_latched <= 1'b0;
                w_latched  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_latched <= 1'b1;
                    aw_index_q <= s_axi.S_AXI_AWADDR[3:2];
                end
                if (w_hs) begin
                    w_latched <= 1'b1;
                    wdata_q   <= s_axi.S_AXI_WDATA;
                    wstrb_q   <= s_axi.S_AXI_WSTRB;
                end
                if (do_write) begin
                    bvalid_q <= 1'b1;
                end
            end
        end
    end

    // Register file update with per-byte strobes.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (do_write) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wr_strb[b]) begin
                    regs[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read channel: RDATA is captured from the pre-write register contents,
    // so a read racing a write to the same register sees the old value.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= regs[s_axi.S_AXI_ARADDR[3:2]];
            end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Tone counter, square wave and sample register.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            counter    <= 32'd0;
            tone_out   <= 1'b0;
            sample_out <= 16'd0;
        end else begin
            tone_out   <= tone_next;
            sample_out <= sample_next;
            if (!tone_enabled || hp_write || tone_wrap) begin
                counter <= 32'd0;
            end else begin
                counter <= counter + 32'd1;
            end
        end
    end

endmodule

// File: doc/tone_gen_axil_slave.md
TONE_GEN_AXIL_SLAVE -- requirements
Module: tone_gen_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, AXI4-Lite byte-address width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 S_AXI_ACLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 S_AXI_ARESET  in  1  asynchronous active-high reset.
REQ-006 S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address; S_AXI_AWPROT  in  3  ignored.
REQ-007 S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1  write-address handshake.
REQ-008 S_AXI_WDATA  in  32  write data; S_AXI_WSTRB  in  4  byte enables.
REQ-009 S_AXI_WVALID in 1 / S_AXI_WREADY out 1  write-data handshake.
REQ-010 S_AXI_BRESP out 2 / S_AXI_BVALID out 1 / S_AXI_BREADY in 1  write response.
REQ-011 S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address; S_AXI_ARPROT  in  3  ignored.
REQ-012 S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1  read-address handshake.
REQ-013 S_AXI_RDATA out 32 / S_AXI_RRESP out 2 / S_AXI_RVALID out 1 / S_AXI_RREADY in 1  read data.
REQ-014 tone_out  out  1  square-wave tone.
REQ-015 sample_out  out  16  signed audio sample, +/-amplitude.

Function
REQ-016 Register map, decode on address bits [3:2], other bits ignored: 0x0 CTRL (bit0 = enable), 0x4 HALF_PERIOD (cycles), 0x8 AMPLITUDE (bits[15:0] used), 0xC SCRATCH; all four 32-bit read/write, and reads SHALL return the full stored 32 bits.
REQ-017 AW and W channels SHALL be accepted independently: AWREADY high while no address is latched and BVALID low; WREADY high while no data is latched and BVALID low.
REQ-018 Once both address and data are latched, the register write SHALL occur on that same edge, with each byte applied only where its WSTRB bit is 1, and BVALID SHALL assert the next cycle.
REQ-019 BVALID SHALL hold with BRESP=00 until the cycle BREADY is high; the AW/W latches then clear and AWREADY/WREADY reassert on the following cycle.
REQ-020 ARREADY SHALL be high while RVALID is low; on the AR handshake, RDATA is registered and RVALID asserts the next cycle; RDATA/RVALID hold, RRESP=00, until RREADY.
REQ-021 Read and write channels SHALL operate concurrently; a same-cycle read of a register being written SHALL return the pre-write value.
REQ-022 The tone counter (32-bit) SHALL increment each cycle while CTRL[0]=1 and HALF_PERIOD!=0; when it equals HALF_PERIOD-1 it SHALL wrap to 0 and tone_out SHALL toggle.
REQ-023 While CTRL[0]=0 or HALF_PERIOD=0: counter=0 and tone_out=0 on the next edge.
REQ-024 Any write to HALF_PERIOD SHALL clear the counter on the write edge; tone_out keeps its level.
REQ-025 sample_out SHALL be registered: AMPLITUDE[15:0] when tone_out=1, its two's-complement negation (wrapping, 16-bit) when tone_out=0 and enabled, 0 when disabled.

Reset
REQ-026 On S_AXI_ARESET high, asynchronously: all registers=0, counter=0, tone_out=0, sample_out=0, BVALID=0, RVALID=0, AW/W latches cleared, AWREADY=WREADY=ARREADY=0.
REQ-027 Ready signals SHALL reassert on the first edge after reset deasserts; a transaction in flight at reset is discarded with no response.

Verification
REQ-028 Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0/0x4/0x8/0xC, read each back -> identical data, BRESP=RRESP=00.
REQ-029 W presented 3 cycles before AW, BREADY held low 5 cycles -> single write, BVALID held 5 cycles, AWREADY/WREADY low until after B handshake.
REQ-030 WSTRB=0010 with WDATA=0x12345678 to SCRATCH holding 0 -> readback 0x00005600.
REQ-031 HALF_PERIOD=4, AMPLITUDE=0x1000, CTRL=1 -> tone_out toggles every 4 cycles (period 8), sample_out alternates 0x1000/0xF000.
REQ-032 Clear CTRL mid-tone -> tone_out=0, sample_out=0 next cycle; rewrite HALF_PERIOD=0 with CTRL=1 -> tone_out stays 0.
REQ-033 Assert S_AXI_ARESET while BVALID high -> BVALID drops immediately, all registers read back 0 after reset release.
